// File: rtl/adder_pipeline_error_monitor_if.sv
// Bundle between the parity-protected adder pipeline (plus its upstream
// source) and adder_pipeline_error_monitor.
//   master : drives in_valid, sum, err_alarm, error_signals; observes results
//   slave  : the monitor; consumes pipeline signals, drives ready/results/status
interface adder_pipeline_error_monitor_if #(
  parameter int WORD_WIDTH    = 4,
  parameter int LAYERS        = 3,
  parameter int ERR_CNT_WIDTH = 4
);
  logic                     in_valid;
  logic [WORD_WIDTH-1:0]    sum;
  logic                     err_alarm;
  logic [LAYERS-1:0]        error_signals;
  logic                     in_ready;
  logic [WORD_WIDTH-1:0]    out_data;
  logic                     out_valid;
  logic                     out_corrupt;
  logic                     flush;
  logic [ERR_CNT_WIDTH-1:0] err_count;
  logic [LAYERS-1:0]        err_layer;
  logic                     fail;

  modport master (
    output in_valid, sum, err_alarm, error_signals,
    input  in_ready, out_data, out_valid, out_corrupt, flush, err_count, err_layer, fail
  );

  modport slave (
    input  in_valid, sum, err_alarm, error_signals,
    output in_ready, out_data, out_valid, out_corrupt, flush, err_count, err_layer, fail
  );
endinterface

// File: rtl/adder_pipeline_error_monitor.sv
// Error monitor for the cascaded parity-protected adder pipeline.
// Tracks real data through the pipeline with a valid-token delay line,
// emits registered results, drains the pipeline after a parity alarm,
// counts error episodes and latches a sticky failure at FAIL_THRESHOLD.
// Ports:
//   clk   - rising-edge clock shared with the pipeline
//   rst_n - asynchronous active-low reset
//   bus   - slave side of adder_pipeline_error_monitor_if
//
// state   | meaning
// --------+-------------------------------------------------------------
// RUN     | accepting input, emitting results of tokens reaching the end
// FLUSH   | input blocked, discarding in-flight tokens for LAYERS clocks
// FAILED  | threshold reached; input blocked until reset
module adder_pipeline_error_monitor #(
  parameter int WORD_WIDTH     = 4,
  parameter int LAYERS         = 3,
  parameter int ERR_CNT_WIDTH  = 4,
  parameter int FAIL_THRESHOLD = 3
) (
  input  logic clk,
  input  logic rst_n,
  adder_pipeline_error_monitor_if.slave bus
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_FLUSH  = 2'd1;
  localparam logic [1:0] ST_FAILED = 2'd2;

  localparam int CW = $clog2(LAYERS + 1);
  localparam logic [CW-1:0]            DRAIN_LOAD = CW'(LAYERS);
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_THR    = ERR_CNT_WIDTH'(FAIL_THRESHOLD);

  logic [1:0]               state_q, state_d;
  logic [CW-1:0]            drain_q, drain_d;
  logic [LAYERS-1:0]        vld_sr_q, vld_sr_d;
  logic [WORD_WIDTH-1:0]    out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_corrupt_q, out_corrupt_d;
  logic                     flush_q, flush_d;
  logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;
  logic [LAYERS-1:0]        err_layer_q, err_layer_d;
  logic                     fail_q, fail_d;

  logic in_ready;
  logic accept;
  logic tok;

  assign in_ready = (state_q == ST_RUN);
  assign accept   = bus.in_valid & in_ready;
  assign tok      = vld_sr_q[LAYERS-1];
  // Shift form keeps LAYERS=1 legal.
  assign vld_sr_d = (vld_sr_q << 1) | LAYERS'(accept);

  always_comb begin
    state_d       = state_q;
    drain_d       = drain_q;
    out_data_d    = out_data_q;
    out_valid_d   = 1'b0;
    out_corrupt_d = 1'b0;
    err_count_d   = err_count_q;
    err_layer_d   = err_layer_q;
    case (state_q)
      ST_RUN: begin
        if (bus.err_alarm) begin
          if (err_count_q != CNT_MAX) err_count_d = err_count_q + 1'b1;
          err_layer_d   = err_layer_q | bus.error_signals;
          drain_d       = DRAIN_LOAD;
          state_d       = ST_FLUSH;
          out_corrupt_d = tok;
        end else if (tok) begin
          out_data_d  = bus.sum;
          out_valid_d = 1'b1;
        end
      end
      ST_FLUSH: begin
        out_corrupt_d = tok;
        if (bus.err_alarm) begin
          // Alarm inside a drain extends the same episode.
          drain_d = DRAIN_LOAD;
        end else if (drain_q <= CW'(1)) begin
          drain_d = '0;
          state_d = (err_count_q >= CNT_THR) ? ST_FAILED : ST_RUN;
        end else begin
          drain_d = drain_q - CW'(1);
        end
      end
      ST_FAILED: begin
        out_corrupt_d = tok;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    flush_d = (state_d == ST_FLUSH);
    fail_d  = (state_d == ST_FAILED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      drain_q       <= '0;
      vld_sr_q      <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_corrupt_q <= 1'b0;
      flush_q       <= 1'b0;
      err_count_q   <= '0;
      err_layer_q   <= '0;
      fail_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      drain_q       <= drain_d;
      vld_sr_q      <= vld_sr_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_corrupt_q <= out_corrupt_d;
      flush_q       <= flush_d;
      err_count_q   <= err_count_d;
      err_layer_q   <= err_layer_d;
      fail_q        <= fail_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_data    = out_data_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_corrupt = out_corrupt_q;
  assign bus.flush       = flush_q;
  assign bus.err_count   = err_count_q;
  assign bus.err_layer   = err_layer_q;
  assign bus.fail        = fail_q;

endmodule

// File: tb/tb_adder_pipeline_error_monitor.sv
// Bench for adder_pipeline_error_monitor. Instance A (threshold 3) is fed by a
// stub pipeline (sum = 8*input delayed 3 clocks) and checked by a scoreboard;
// instance B (threshold 15) exercises the long episode run.
module tb_adder_pipeline_error_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rstb_n = 1'b0;
  always #5 clk = ~clk;

  adder_pipeline_error_monitor_if #(.WORD_WIDTH(4), .LAYERS(3), .ERR_CNT_WIDTH(4)) ifa ();
  adder_pipeline_error_monitor_if #(.WORD_WIDTH(4), .LAYERS(3), .ERR_CNT_WIDTH(4)) ifb ();

  adder_pipeline_error_monitor #(
    .WORD_WIDTH(4), .LAYERS(3), .ERR_CNT_WIDTH(4), .FAIL_THRESHOLD(3)
  ) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));

  adder_pipeline_error_monitor #(
    .WORD_WIDTH(4), .LAYERS(3), .ERR_CNT_WIDTH(4), .FAIL_THRESHOLD(15)
  ) dut_b (.clk(clk), .rst_n(rstb_n), .bus(ifb.slave));

  // Stub adder pipeline: sum = 8*input, three clocks of latency.
  logic [3:0] in_data = '0;
  logic [3:0] pipe0 = '0, pipe1 = '0, pipe2 = '0;
  always @(posedge clk) begin
    pipe0 <= 4'(in_data * 4'd8);
    pipe1 <= pipe0;
    pipe2 <= pipe1;
  end
  assign ifa.sum = pipe2;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // kind: 1 = emitted with out_valid, 2 = discarded with out_corrupt
  typedef struct {
    int         kind;
    logic [3:0] data;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    bit         v;
    logic [3:0] d;
    bit         e;
    logic [2:0] es;
    int         exp;
    logic [3:0] xd;
  } vec_t;

  function automatic vec_t V(bit v, logic [3:0] d, bit e, logic [2:0] es, int exp, logic [3:0] xd);
    vec_t t;
    t.v = v; t.d = d; t.e = e; t.es = es; t.exp = exp; t.xd = xd;
    return t;
  endfunction

  task automatic play(input vec_t t);
    exp_t x;
    @(negedge clk);
    ifa.in_valid      = t.v;
    in_data           = t.d;
    ifa.err_alarm     = t.e;
    ifa.error_signals = t.es;
    if (t.exp != 0) begin
      x.kind = t.exp;
      x.data = t.xd;
      sb_q.push_back(x);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) play(V(0, 0, 0, 3'b000, 0, 0));
  endtask

  // Monitor: pops one expectation for every output event.
  always @(negedge clk) begin
    exp_t x;
    if (rst_n && (ifa.out_valid || ifa.out_corrupt)) begin
      chk("pulse_exclusive", ifa.out_valid & ifa.out_corrupt, 0);
      chk("sb_has_entry", sb_q.size() > 0, 1);
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        chk("sb_kind", ifa.out_corrupt ? 2 : 1, x.kind);
        if (x.kind == 1) chk("sb_data", ifa.out_data, x.data);
      end
    end
  end

  // Cycle counters sampled just after each rising edge.
  int fl_cnt = 0, nr_cnt = 0, rd_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (ifa.flush) fl_cnt++;
    if (!ifa.in_ready) nr_cnt++;
    if (ifa.in_ready) rd_cnt++;
  end

  task automatic do_reset();
    chk("sb_drained", sb_q.size(), 0);
    @(negedge clk);
    rst_n = 1'b0;
    ifa.in_valid = 1'b0; ifa.err_alarm = 1'b0; ifa.error_signals = '0; in_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fl_cnt = 0; nr_cnt = 0; rd_cnt = 0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ifa.in_valid = 1'b0; ifa.err_alarm = 1'b0; ifa.error_signals = '0;
    ifb.in_valid = 1'b0; ifb.err_alarm = 1'b0; ifb.error_signals = 3'b001; ifb.sum = '0;

    // Reset state
    do_reset();
    chk("rst_in_ready", ifa.in_ready, 1);
    chk("rst_out_valid", ifa.out_valid, 0);
    chk("rst_out_data", ifa.out_data, 0);
    chk("rst_flush", ifa.flush, 0);
    chk("rst_err_count", ifa.err_count, 0);
    chk("rst_fail", ifa.fail, 0);

    // 1: three clean words -> 8, 0, 8
    play(V(1, 1, 0, 3'b000, 1, 4'd8));
    play(V(1, 2, 0, 3'b000, 1, 4'd0));
    play(V(1, 3, 0, 3'b000, 1, 4'd8));
    idle(5);
    chk("t1_err_count", ifa.err_count, 0);
    chk("t1_in_ready", ifa.in_ready, 1);

    // 2: single-cycle alarm while the token is at the pipeline output
    do_reset();
    play(V(1, 1, 0, 3'b000, 2, 4'd8));
    idle(2);
    play(V(0, 0, 1, 3'b010, 0, 0));
    play(V(1, 7, 0, 3'b000, 0, 0));   // blocked, must not enter the pipeline
    idle(2);
    play(V(1, 2, 0, 3'b000, 1, 4'd0));
    idle(5);
    chk("t2_flush_cycles", fl_cnt, 3);
    chk("t2_notready_cycles", nr_cnt, 3);
    chk("t2_err_count", ifa.err_count, 1);
    chk("t2_err_layer", ifa.err_layer, 3'b010);
    chk("t2_back_in_run", ifa.in_ready, 1);

    // 3: alarm again at flush cycle 2 restarts the drain
    do_reset();
    play(V(1, 5, 0, 3'b000, 2, 4'd8));
    play(V(1, 6, 0, 3'b000, 2, 4'd0));
    idle(1);
    play(V(0, 0, 1, 3'b100, 0, 0));
    idle(1);
    play(V(0, 0, 1, 3'b001, 0, 0));
    idle(3);
    play(V(1, 3, 0, 3'b000, 1, 4'd8));
    idle(5);
    chk("t3_flush_cycles", fl_cnt, 5);
    chk("t3_err_count", ifa.err_count, 1);
    chk("t3_err_layer", ifa.err_layer, 3'b100);

    // 4: three episodes reach the threshold
    do_reset();
    play(V(0, 0, 1, 3'b001, 0, 0));
    idle(3);
    play(V(1, 1, 1, 3'b010, 2, 4'd8));
    idle(3);
    play(V(1, 2, 1, 3'b100, 2, 4'd0));
    idle(3);
    rd_cnt = 0;
    play(V(0, 0, 1, 3'b000, 0, 0));
    idle(1);
    play(V(0, 0, 1, 3'b000, 0, 0));
    idle(5);
    chk("t4_err_count", ifa.err_count, 3);
    chk("t4_fail", ifa.fail, 1);
    chk("t4_flush", ifa.flush, 0);
    chk("t4_in_ready", ifa.in_ready, 0);
    chk("t4_ready_cycles", rd_cnt, 0);
    chk("t4_err_layer", ifa.err_layer, 3'b111);

    // 5: asynchronous reset in the middle of a drain
    do_reset();
    play(V(1, 1, 0, 3'b000, 1, 4'd8));
    idle(3);
    play(V(0, 0, 1, 3'b011, 0, 0));
    idle(1);
    chk("t5_pre_flush", ifa.flush, 1);
    chk("t5_pre_out_data", ifa.out_data, 8);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_in_ready", ifa.in_ready, 1);
    chk("t5_flush", ifa.flush, 0);
    chk("t5_out_data", ifa.out_data, 0);
    chk("t5_out_valid", ifa.out_valid, 0);
    chk("t5_out_corrupt", ifa.out_corrupt, 0);
    chk("t5_err_count", ifa.err_count, 0);
    chk("t5_err_layer", ifa.err_layer, 0);
    chk("t5_fail", ifa.fail, 0);
    #1 rst_n = 1'b1;
    idle(4);

    // 6: fifteen episodes on instance B, then alarms while FAILED
    @(negedge clk);
    rstb_n = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      ifb.err_alarm = 1'b1;
      @(negedge clk);
      ifb.err_alarm = 1'b0;
      chk("t6_err_count_step", ifb.err_count, i);
      repeat (3) @(negedge clk);
    end
    chk("t6_fail", ifb.fail, 1);
    chk("t6_in_ready", ifb.in_ready, 0);
    for (int i = 0; i < 4; i++) begin
      ifb.err_alarm = 1'b1;
      @(negedge clk);
      ifb.err_alarm = 1'b0;
      @(negedge clk);
    end
    chk("t6_err_count_hold", ifb.err_count, 15);
    chk("t6_fail_hold", ifb.fail, 1);
    chk("t6_flush", ifb.flush, 0);

    chk("sb_final_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
